serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: computes diff = a - b, one bit per clock, LSB first.

---
 rtl/serial_subtractor_if.sv | 12 +
 rtl/serial_subtractor.sv | 68 ++++++
 tb/tb_serial_subtractor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake bus carrying the operands and the result of a bit-serial subtraction
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b using one full-subtractor cell and a borrow flip-flop
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_sr, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bf, r_borrow;
  logic             w_x, w_y, w_d, w_bo;
  logic [WIDTH-1:0] w_sr_next;
  assign w_x       = r_sa[0];
  assign w_y       = r_sb[0];
  assign w_d       = w_x ^ w_y ^ r_bf;
  assign w_bo      = (~w_x & w_y) | (~(w_x ^ w_y) & r_bf);
  assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};
  assign bus.busy   = r_state == RUN;
  assign bus.done   = r_state == DONE;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_bf     <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_sr    <= '0;
            r_bf    <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_next;
          r_bf  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          // the last bit's shifted value goes straight to diff on the same edge
          if (r_cnt == LAST) begin
            r_diff   <= w_sr_next;
            r_borrow <= w_bo;
            r_state  <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against a plain-arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [7:0] prev_diff;
  logic       prev_bor;
  serial_subtractor_if #(.WIDTH(8)) bus ();
  serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic wait_done(output int at, output bit seen);
    seen = 0;
    at = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done) begin
        seen = 1;
        at = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int glitch);
    logic [7:0] ed;
    logic       eb;
    int         nb;
    bit         seen;
    ed = 8'((9'(a) - 9'(b)) & 9'h0FF);
    eb = a < b;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    chk("hold_diff", bus.diff, prev_diff);
    chk("hold_borrow", bus.borrow, prev_bor);
    nb = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        if (bus.busy) nb++;
        if (glitch != 0 && nb == glitch) begin
          bus.start = 1'b1;
          bus.a = 8'h00;
          bus.b = 8'hFF;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    chk("busy_cycles", nb, 8);
    chk("diff", bus.diff, ed);
    chk("borrow", bus.borrow, eb);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    prev_diff = ed;
    prev_bor = eb;
  endtask
  initial begin
    int  t1, t2;
    bit  s1, s2;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
    rst_n = 1'b1;
    prev_diff = 8'h00;
    prev_bor = 1'b0;
    @(negedge clk);
    run_op(8'h35, 8'h12, 0);
    run_op(8'h12, 8'h35, 0);
    run_op(8'h00, 8'h01, 0);
    run_op(8'hAA, 8'hAA, 0);
    run_op(8'hFF, 8'h00, 0);
    run_op(8'h80, 8'h01, 3);
    chk("ignored_start", bus.diff, 8'h7F);
    // back-to-back: start held high across the DONE cycle
    bus.start = 1'b1;
    bus.a = 8'h10;
    bus.b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.a = 8'h01;
    bus.b = 8'h10;
    wait_done(t1, s1);
    chk("b2b_done1", 32'(s1), 1);
    chk("b2b_diff1", bus.diff, 8'h0F);
    chk("b2b_borrow1", bus.borrow, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy2", bus.busy, 1);
    wait_done(t2, s2);
    chk("b2b_done2", 32'(s2), 1);
    chk("b2b_spacing", t2 - t1, 9);
    chk("b2b_diff2", bus.diff, 8'hF1);
    chk("b2b_borrow2", bus.borrow, 1);
    @(negedge clk);
    prev_diff = 8'hF1;
    prev_bor = 1'b1;
    // reset in the middle of RUN
    bus.start = 1'b1;
    bus.a = 8'h77;
    bus.b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_diff", bus.diff, 0);
    chk("mrst_borrow", bus.borrow, 0);
    rst_n = 1'b1;
    prev_diff = 8'h00;
    prev_bor = 1'b0;
    run_op(8'h05, 8'h03, 0);
    for (int n = 0; n < 1000; n++)
      run_op(8'($urandom), 8'($urandom), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
